// File: rtl/pc_reg_pkg.sv
// Shared fetch-path constants and types: ROM index width, start PC and
// per-clock PC step. Reused by the ROM and fetch-unit wrapper.
package pc_reg_pkg;

    localparam int unsigned FETCH_ADDR_W   = 6;
    localparam int unsigned FETCH_RESET_PC = 0;
    localparam int unsigned FETCH_STEP     = 1;

    typedef logic [FETCH_ADDR_W-1:0] pc_t;

endpackage

// File: rtl/pc_reg_en_flop.sv
// Enable flop: cleared asynchronously by reset, set on the first clock after release.
// Latency: 1 clock from reset release to q=1.
// Backpressure: none; free-running once set.
module en_flop (
    input  logic clk,
    input  logic rst,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_reg.sv
// Program-counter generator: word-index fetch address plus ROM fetch enable.
// Latency: ce and pc=RESET_PC on the 1st edge after reset release, +STEP per edge after.
// Backpressure: none; advances every clock once enabled, wrapping mod 2^ADDR_W.
module pc_reg
    import pc_reg_pkg::*;
#(
    parameter int unsigned ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned RESET_PC = FETCH_RESET_PC,
    parameter int unsigned STEP     = FETCH_STEP
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    output logic              ce
);

    localparam logic [ADDR_W-1:0] RST_V  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    en_flop u_en_flop (
        .clk (clk),
        .rst (rst),
        .q   (ce)
    );

    // Pre-edge ce gates the increment so the ROM sees RESET_PC for one full enabled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RST_V;
        end else if (!ce) begin
            pc <= RST_V;
        end else begin
            pc <= pc + STEP_V;
        end
    end

    a_idle_pc_at_start: assert property (
        @(posedge clk) disable iff (!rst) !ce |-> (pc == RST_V)
    );

    // A reset pulse between edges drops ce, so two sampled ce=1 edges imply no intervening clear.
    a_pc_advances: assert property (
        @(posedge clk) disable iff (!rst) (ce && $past(ce)) |-> (pc == ADDR_W'($past(pc) + STEP_V))
    );

endmodule

// File: tb/tb_pc_reg.sv
// Directed self-checking bench for pc_reg: default instance plus an
// ADDR_W=4 / RESET_PC=3 / STEP=2 override instance.
module tb_pc_reg;

    logic       clk;
    logic       rst;
    logic       rst_b;
    logic [5:0] pc;
    logic       ce;
    logic [3:0] pc_b;
    logic       ce_b;

    int         checks;
    int         errors;
    logic [5:0] exp_pc;

    pc_reg dut (
        .clk (clk),
        .rst (rst),
        .pc  (pc),
        .ce  (ce)
    );

    pc_reg #(
        .ADDR_W   (4),
        .RESET_PC (3),
        .STEP     (2)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .pc  (pc_b),
        .ce  (ce_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) begin
            step();
            checks++;
            if (ce !== 1'b0 || pc !== 6'd0) begin
                errors++;
                $display("FAIL reset_hold: ce=%b pc=%0d expected ce=0 pc=0", ce, pc);
            end
            checks++;
            if (ce_b !== 1'b0 || pc_b !== 4'd3) begin
                errors++;
                $display("FAIL reset_hold_b: ce=%b pc=%0d expected ce=0 pc=3", ce_b, pc_b);
            end
        end
        @(posedge clk);
        #5 rst = 1'b1;
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 6'd0) begin
            errors++;
            $display("FAIL release_edge1: ce=%b pc=%0d expected ce=1 pc=0", ce, pc);
        end
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 6'd1) begin
            errors++;
            $display("FAIL release_edge2: ce=%b pc=%0d expected ce=1 pc=1", ce, pc);
        end
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 6'd2) begin
            errors++;
            $display("FAIL release_edge3: ce=%b pc=%0d expected ce=1 pc=2", ce, pc);
        end
        exp_pc = 6'd2;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 70; i++) begin
            step();
            exp_pc = exp_pc + 6'd1;
            checks++;
            if (ce !== 1'b1 || pc !== exp_pc) begin
                errors++;
                $display("FAIL free_run[%0d]: ce=%b pc=%0d expected ce=1 pc=%0d", i, ce, pc, exp_pc);
            end
        end
    endtask

    task automatic test_async_mid();
        for (int i = 0; i < 64 && exp_pc != 6'd9; i++) begin
            step();
            exp_pc = exp_pc + 6'd1;
            checks++;
            if (pc !== exp_pc) begin
                errors++;
                $display("FAIL seek_pc9: pc=%0d expected %0d", pc, exp_pc);
            end
        end
        #4 rst = 1'b0;
        #1;
        checks++;
        if (ce !== 1'b0 || pc !== 6'd0) begin
            errors++;
            $display("FAIL async_clear: ce=%b pc=%0d expected ce=0 pc=0", ce, pc);
        end
        step();
        checks++;
        if (ce !== 1'b0 || pc !== 6'd0) begin
            errors++;
            $display("FAIL async_hold: ce=%b pc=%0d expected ce=0 pc=0", ce, pc);
        end
        #4 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ce !== 1'b1 || pc !== 6'(i)) begin
                errors++;
                $display("FAIL async_restart[%0d]: ce=%b pc=%0d expected ce=1 pc=%0d", i, ce, pc, i);
            end
        end
    endtask

    task automatic test_short_pulse();
        step();
        #4 rst = 1'b0;
        #2;
        checks++;
        if (ce !== 1'b0 || pc !== 6'd0) begin
            errors++;
            $display("FAIL pulse_clear: ce=%b pc=%0d expected ce=0 pc=0", ce, pc);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ce !== 1'b0 || pc !== 6'd0) begin
            errors++;
            $display("FAIL pulse_release_wait: ce=%b pc=%0d expected ce=0 pc=0", ce, pc);
        end
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 6'd0) begin
            errors++;
            $display("FAIL pulse_edge1: ce=%b pc=%0d expected ce=1 pc=0", ce, pc);
        end
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 6'd1) begin
            errors++;
            $display("FAIL pulse_edge2: ce=%b pc=%0d expected ce=1 pc=1", ce, pc);
        end
    endtask

    task automatic test_override();
        int exp_b [9] = '{3, 5, 7, 9, 11, 13, 15, 1, 3};
        #4 rst_b = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (ce_b !== 1'b1 || pc_b !== 4'(exp_b[i])) begin
                errors++;
                $display("FAIL override[%0d]: ce=%b pc=%0d expected ce=1 pc=%0d", i, ce_b, pc_b, exp_b[i]);
            end
        end
    endtask

    task automatic test_release_setup();
        rst = 1'b0;
        #1;
        checks++;
        if (ce !== 1'b0 || pc !== 6'd0) begin
            errors++;
            $display("FAIL setup_clear: ce=%b pc=%0d expected ce=0 pc=0", ce, pc);
        end
        @(negedge clk);
        #9 rst = 1'b1;
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 6'd0) begin
            errors++;
            $display("FAIL setup_edge1: ce=%b pc=%0d expected ce=1 pc=0", ce, pc);
        end
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 6'd1) begin
            errors++;
            $display("FAIL setup_edge2: ce=%b pc=%0d expected ce=1 pc=1", ce, pc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_pc = 6'd0;
        rst    = 1'b0;
        rst_b  = 1'b0;
        test_reset();
        test_free_run();
        test_async_mid();
        test_short_pulse();
        test_override();
        test_release_setup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
